// File: rtl/hazard_fwd_unit_pkg.sv
// Shared pipeline definitions for the hazard/forwarding unit: operand-mux select codes,
// register-number width and the per-stage shadow record layouts.
package hazard_fwd_unit_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_MEMWB = 2'b01,
    SEL_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dst;
    logic             reg_write;
    logic             mem_read;
  } idex_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             reg_write;
  } stage_t;

  // The youngest producer (EX/MEM) takes priority over MEM/WB.
  function automatic fwd_sel_e pick_sel(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit) return SEL_EXMEM;
    if (memwb_hit) return SEL_MEMWB;
    return SEL_RF;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_compare.sv
// Single source-vs-stage comparator: true when the stage will write a live,
// non-$0 register equal to the source operand.
module fwd_compare
  import hazard_fwd_unit_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] stage_dst,
  input  logic             stage_valid,
  input  logic             stage_reg_write,
  output logic             match
);

  assign match = stage_valid && stage_reg_write && (stage_dst != '0) && (stage_dst == src);

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline, driven from
// internal ID/EX, EX/MEM and MEM/WB shadow registers.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             bubble,
  output logic [15:0]      stall_count
);

  idex_t  idex;
  stage_t exmem;
  stage_t memwb;

  logic a_exmem, a_memwb, b_exmem, b_memwb;
  logic load_use;

  fwd_compare u_cmp_a_exmem (
    .src(idex.rs), .stage_dst(exmem.dst), .stage_valid(exmem.valid),
    .stage_reg_write(exmem.reg_write), .match(a_exmem)
  );
  fwd_compare u_cmp_a_memwb (
    .src(idex.rs), .stage_dst(memwb.dst), .stage_valid(memwb.valid),
    .stage_reg_write(memwb.reg_write), .match(a_memwb)
  );
  fwd_compare u_cmp_b_exmem (
    .src(idex.rt), .stage_dst(exmem.dst), .stage_valid(exmem.valid),
    .stage_reg_write(exmem.reg_write), .match(b_exmem)
  );
  fwd_compare u_cmp_b_memwb (
    .src(idex.rt), .stage_dst(memwb.dst), .stage_valid(memwb.valid),
    .stage_reg_write(memwb.reg_write), .match(b_memwb)
  );

  always_comb begin
    load_use = idex.valid && idex.mem_read && (idex.dst != '0) && id_valid &&
               ((idex.dst == id_rs) || (idex.dst == id_rt));
    stall    = load_use && !flush;
    bubble   = stall;
    // An empty or squashed EX slot keeps the register-file select, so a
    // flushed consumer never appears forwarded.
    fwd_a_sel = idex.valid ? pick_sel(a_exmem, a_memwb) : SEL_RF;
    fwd_b_sel = idex.valid ? pick_sel(b_exmem, b_memwb) : SEL_RF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex        <= '0;
      exmem       <= '0;
      memwb       <= '0;
      stall_count <= '0;
    end else begin
      idex.valid      <= id_valid && !bubble && !flush;
      idex.rs         <= id_rs;
      idex.rt         <= id_rt;
      idex.dst        <= id_dst;
      idex.reg_write  <= id_reg_write;
      idex.mem_read   <= id_mem_read;
      exmem.valid     <= idex.valid;
      exmem.dst       <= idex.dst;
      exmem.reg_write <= idex.reg_write;
      memwb           <= exmem;
      if (stall && (stall_count != '1)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: a cycle-history model of which instruction
// occupied EX on each past cycle, checked every cycle, plus hand-computed literals.
module tb_hazard_fwd_unit;

  typedef struct {
    bit       v;
    bit [4:0] rs;
    bit [4:0] rt;
    bit [4:0] dst;
    bit       wr;
    bit       ld;
  } ins_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_reg_write, id_mem_read;
  logic        flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall, bubble;
  logic [15:0] stall_count;

  int unsigned total  = 0;
  int unsigned passed = 0;
  bit          chk_on = 1'b0;

  // hist[k] = instruction that was in EX k cycles ago (k=0: now in EX).
  ins_t        hist [3];
  ins_t        cur;
  bit          cur_flush;
  int unsigned mcnt;

  hazard_fwd_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .bubble(bubble), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic ins_t mk(bit v, bit [4:0] rs, bit [4:0] rt, bit [4:0] dst, bit wr, bit ld);
    ins_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.dst = dst; r.wr = wr; r.ld = ld;
    return r;
  endfunction

  function automatic bit writes(ins_t p, bit [4:0] s);
    return p.v && p.wr && (p.dst != 0) && (p.dst == s);
  endfunction

  function automatic logic [1:0] m_sel(bit [4:0] s);
    if (!hist[0].v) return 2'b00;
    if (writes(hist[1], s)) return 2'b10;
    if (writes(hist[2], s)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    return !cur_flush && cur.v && hist[0].v && hist[0].ld && (hist[0].dst != 0) &&
           ((hist[0].dst == cur.rs) || (hist[0].dst == cur.rt));
  endfunction

  task automatic ck(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic m_clear();
    for (int i = 0; i < 3; i++) hist[i] = mk(0, 0, 0, 0, 0, 0);
    mcnt = 0;
  endtask

  task automatic drive(ins_t i, bit f);
    cur = i; cur_flush = f;
    id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_dst = i.dst;
    id_reg_write = i.wr; id_mem_read = i.ld; flush = f;
  endtask

  task automatic cyc(ins_t i, bit f);
    drive(i, f);
    @(negedge clk);
  endtask

  task automatic adv();
    bit   s;
    ins_t nxt;
    s   = m_stall();
    nxt = (cur.v && !s && !cur_flush) ? cur : mk(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = nxt;
    if (s && mcnt != 32'hFFFF) mcnt++;
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) begin
      cyc(mk(0, 0, 0, 0, 0, 0), 0);
      adv();
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      ck("fwd_a_sel", {14'd0, fwd_a_sel}, {14'd0, m_sel(hist[0].rs)});
      ck("fwd_b_sel", {14'd0, fwd_b_sel}, {14'd0, m_sel(hist[0].rt)});
      ck("stall", {15'd0, stall}, {15'd0, m_stall()});
      ck("bubble", {15'd0, bubble}, {15'd0, m_stall()});
      ck("stall_count", stall_count, mcnt[15:0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t nop, lw2, add422;
    nop    = mk(0, 0, 0, 0, 0, 0);
    lw2    = mk(1, 1, 0, 2, 1, 1);
    add422 = mk(1, 2, 2, 4, 1, 0);

    reset = 1'b1;
    drive(lw2, 0);
    m_clear();
    chk_on = 1'b1;
    @(posedge clk); #1;
    ck("rst_stall", {15'd0, stall}, 16'd0);
    ck("rst_bubble", {15'd0, bubble}, 16'd0);
    ck("rst_fwd_a", {14'd0, fwd_a_sel}, 16'd0);
    ck("rst_count", stall_count, 16'd0);
    drive(nop, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // add r3<-r1,r2 ; sub r4<-r3,r5
    cyc(mk(1, 1, 2, 3, 1, 0), 0); adv();
    cyc(mk(1, 3, 5, 4, 1, 0), 0); ck("s1_nostall", {15'd0, stall}, 16'd0); adv();
    cyc(nop, 0);
    ck("s1_fwd_a", {14'd0, fwd_a_sel}, 16'h2);
    ck("s1_fwd_b", {14'd0, fwd_b_sel}, 16'h0);
    adv(); drain(2);

    // add r3 ; nop ; or r6<-r5,r3
    cyc(mk(1, 1, 2, 3, 1, 0), 0); adv();
    cyc(nop, 0); adv();
    cyc(mk(1, 5, 3, 6, 1, 0), 0); adv();
    cyc(nop, 0);
    ck("s2_fwd_b", {14'd0, fwd_b_sel}, 16'h1);
    ck("s2_fwd_a", {14'd0, fwd_a_sel}, 16'h0);
    adv(); drain(2);

    // two producers of r3 back to back: the younger one must win
    cyc(mk(1, 1, 2, 3, 1, 0), 0); adv();
    cyc(mk(1, 7, 8, 3, 1, 0), 0); adv();
    cyc(mk(1, 3, 3, 4, 1, 0), 0); adv();
    cyc(nop, 0);
    ck("prio_fwd_a", {14'd0, fwd_a_sel}, 16'h2);
    ck("prio_fwd_b", {14'd0, fwd_b_sel}, 16'h2);
    adv(); drain(2);

    // lw r2 ; add r4<-r2,r2
    cyc(lw2, 0); ck("s3_lw_nostall", {15'd0, stall}, 16'd0); adv();
    cyc(add422, 0);
    ck("s3_stall", {15'd0, stall}, 16'd1);
    ck("s3_bubble", {15'd0, bubble}, 16'd1);
    adv();
    cyc(add422, 0); ck("s3_one_cycle", {15'd0, stall}, 16'd0); adv();
    cyc(nop, 0);
    ck("s3_fwd_a", {14'd0, fwd_a_sel}, 16'h1);
    ck("s3_fwd_b", {14'd0, fwd_b_sel}, 16'h1);
    ck("s3_count", stall_count, 16'd1);
    adv(); drain(2);

    // lw r2 ; lw r3<-(r2) ; add r5<-r3,r0
    cyc(lw2, 0); adv();
    cyc(mk(1, 2, 0, 3, 1, 1), 0); ck("b2b_stall1", {15'd0, stall}, 16'd1); adv();
    cyc(mk(1, 2, 0, 3, 1, 1), 0); ck("b2b_gap1", {15'd0, stall}, 16'd0); adv();
    cyc(mk(1, 3, 0, 5, 1, 0), 0);
    ck("b2b_stall2", {15'd0, stall}, 16'd1);
    ck("b2b_lw_addr_fwd", {14'd0, fwd_a_sel}, 16'h1);
    adv();
    cyc(mk(1, 3, 0, 5, 1, 0), 0); ck("b2b_gap2", {15'd0, stall}, 16'd0); adv();
    cyc(nop, 0);
    ck("b2b_fwd_a", {14'd0, fwd_a_sel}, 16'h1);
    ck("b2b_count", stall_count, 16'd3);
    adv(); drain(2);

    // add r0 ; lw r0 ; reader of r0
    cyc(mk(1, 1, 2, 0, 1, 0), 0); adv();
    cyc(mk(1, 1, 0, 0, 1, 1), 0); adv();
    cyc(mk(1, 0, 0, 7, 1, 0), 0); ck("r0_nostall", {15'd0, stall}, 16'd0); adv();
    cyc(nop, 0);
    ck("r0_fwd_a", {14'd0, fwd_a_sel}, 16'h0);
    ck("r0_fwd_b", {14'd0, fwd_b_sel}, 16'h0);
    adv(); drain(2);

    // lw r2 ; dependent add squashed by flush in the hazard cycle
    cyc(lw2, 0); adv();
    cyc(add422, 1);
    ck("fl_stall", {15'd0, stall}, 16'd0);
    ck("fl_bubble", {15'd0, bubble}, 16'd0);
    adv();
    cyc(nop, 0);
    ck("fl_fwd_a", {14'd0, fwd_a_sel}, 16'h0);
    ck("fl_fwd_b", {14'd0, fwd_b_sel}, 16'h0);
    adv();
    cyc(nop, 0); ck("fl_count", stall_count, 16'd3); adv();
    drain(1);

    // reset pulsed in the middle of a load-use stall
    cyc(lw2, 0); adv();
    cyc(add422, 0); ck("rs_pre_stall", {15'd0, stall}, 16'd1);
    #1 reset = 1'b1;
    m_clear();
    #1;
    ck("rs_async_stall", {15'd0, stall}, 16'd0);
    ck("rs_async_bubble", {15'd0, bubble}, 16'd0);
    ck("rs_async_count", stall_count, 16'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(add422, 0);
    ck("rs_post_stall", {15'd0, stall}, 16'd0);
    ck("rs_post_fwd_a", {14'd0, fwd_a_sel}, 16'h0);
    ck("rs_post_fwd_b", {14'd0, fwd_b_sel}, 16'h0);
    adv();
    cyc(nop, 0); ck("rs_post_count", stall_count, 16'd0); adv();
    drain(2);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
